// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encodings, operation
// latencies and the controller state type.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Number of cycles busy stays high for each arithmetic class.
  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;

endpackage

// File: rtl/mdu_div.sv
// 32-bit signed/unsigned divider: quotient truncates toward zero, remainder
// follows the dividend's sign. A zero divisor yields zero outputs.
import mdu_pkg::*;

module mdu_div (
  input  logic        i_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem
);

  logic        w_negA;
  logic        w_negB;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_negA = i_signed & i_a[31];
  assign w_negB = i_signed & i_b[31];
  assign w_absA = w_negA ? (32'd0 - i_a) : i_a;
  assign w_absB = w_negB ? (32'd0 - i_b) : i_b;

  // Magnitude divide; 0x80000000 / -1 wraps back to 0x80000000 after negation.
  assign w_q = (w_absB == 32'd0) ? 32'd0 : (w_absA / w_absB);
  assign w_r = (w_absB == 32'd0) ? 32'd0 : (w_absA % w_absB);

  assign o_quo = (w_negA ^ w_negB) ? (32'd0 - w_q) : w_q;
  assign o_rem = w_negA ? (32'd0 - w_r) : w_r;

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers and a fixed-latency
// busy window. Define MDU_DIV_EN to build in DIV/DIVU support.
import mdu_pkg::*;

module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] SA,
  input  logic [31:0] SB,
  output logic        busy,
  output logic [31:0] MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e  r_state;
  mdu_state_e  w_stateNext;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cntNext;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_isMul;
  logic        w_isDiv;
  logic        w_accept;
  logic        w_done;
  logic        w_mulSigned;
  logic [63:0] w_aExt;
  logic [63:0] w_bExt;
  logic [63:0] w_prod;

  assign w_isMul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);

`ifdef MDU_DIV_EN
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_isDiv = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);

  mdu_div u_div (
    .i_signed (r_op == OP_DIV),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_quo    (w_quo),
    .o_rem    (w_rem)
  );
`else
  assign w_isDiv = 1'b0;
`endif

  // Sign- or zero-extend to 64 bits so one low-half product serves both forms.
  assign w_mulSigned = (r_op == OP_MULT);
  assign w_aExt      = {{32{w_mulSigned & r_a[31]}}, r_a};
  assign w_bExt      = {{32{w_mulSigned & r_b[31]}}, r_b};
  assign w_prod      = w_aExt * w_bExt;

  assign w_done = (r_state == ST_BUSY) && (r_cnt == 4'd0);

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (w_isMul || w_isDiv)) begin
          w_stateNext = ST_BUSY;
          w_accept    = 1'b1;
          w_cntNext   = w_isDiv ? (DIV_LAT - 4'd1) : (MUL_LAT - 4'd1);
        end
      end
      ST_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_stateNext = ST_IDLE;
        end else begin
          w_cntNext = r_cnt - 4'd1;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= OP_NONE;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      if (w_accept) begin
        r_op <= mdu_op;
        r_a  <= SA;
        r_b  <= SB;
      end
      if (r_state == ST_IDLE && start && mdu_op == OP_MTHI) r_hi <= SA;
      if (r_state == ST_IDLE && start && mdu_op == OP_MTLO) r_lo <= SA;
      // A zero divisor completes its busy window without touching HI/LO.
      if (w_done) begin
        if (r_op == OP_MULT || r_op == OP_MULTU) begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end
`ifdef MDU_DIV_EN
        else if (r_b != 32'd0) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end
`endif
      end
    end
  end

  assign busy   = (r_state == ST_BUSY);
  assign HI     = r_hi;
  assign LO     = r_lo;
  assign MDUOut = (mdu_op == OP_MFHI) ? r_hi :
                  (mdu_op == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios then random operations
// compared against an arithmetic reference model of HI/LO and busy length.
module tb_mdu;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] SA;
  logic [31:0] SB;
  logic        busy;
  logic [31:0] MDUOut;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] expHi = 32'd0;
  logic [31:0] expLo = 32'd0;
  int expLat = 0;
  int nBusy;

  mdu dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .SA     (SA),
    .SB     (SB),
    .busy   (busy),
    .MDUOut (MDUOut),
    .HI     (HI),
    .LO     (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural effect of one accepted operation.
  task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    expLat = 0;
    case (op)
      4'd1: begin p = 64'(sa * sb); expHi = p[63:32]; expLo = p[31:0]; expLat = 5; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; expHi = p[63:32]; expLo = p[31:0]; expLat = 5; end
      4'd3: if (DIV_EN) begin
        expLat = 10;
        if (b != 0) begin
          q = sa / sb; r = sa % sb;
          expLo = q[31:0]; expHi = r[31:0];
        end
      end
      4'd4: if (DIV_EN) begin
        expLat = 10;
        if (b != 0) begin expLo = a / b; expHi = a % b; end
      end
      4'd7: expHi = a;
      4'd8: expLo = a;
      default: ;
    endcase
  endtask

  // Issue one op, count busy cycles (bounded), optionally poke a stray MTLO
  // and scramble operands on busy cycle interfereAt.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int interfereAt);
    start = 1'b1; mdu_op = op; SA = a; SB = b;
    tick();
    start = 1'b0; mdu_op = 4'd0;
    nBusy = 0;
    while (busy && nBusy < 20) begin
      nBusy++;
      if (nBusy == 2) begin
        mdu_op = 4'd6;
        #1;
        checkOutput("MDUOut MFLO during busy", MDUOut, expLo);
        mdu_op = 4'd0;
      end
      if (nBusy == interfereAt) begin
        start = 1'b1; mdu_op = 4'd8; SA = $urandom; SB = $urandom;
      end
      tick();
      start = 1'b0; mdu_op = 4'd0;
    end
    modelOp(op, a, b);
    checkOutput("busy length", 32'(nBusy), 32'(expLat));
    checkOutput("HI", HI, expHi);
    checkOutput("LO", LO, expLo);
  endtask

  task automatic checkReads();
    mdu_op = 4'd5; #1; checkOutput("MDUOut MFHI", MDUOut, expHi);
    mdu_op = 4'd6; #1; checkOutput("MDUOut MFLO", MDUOut, expLo);
    mdu_op = 4'($urandom_range(9, 15)); #1; checkOutput("MDUOut other op", MDUOut, 32'd0);
    mdu_op = 4'd0;
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; mdu_op = 4'd0; SA = 32'd0; SB = 32'd0;
    tick(); tick();
    reset = 1'b1;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset HI", HI, 32'd0);
    checkOutput("reset LO", LO, 32'd0);
    checkReads();

    applyStimulus(4'd1, 32'hFFFF_FFFF, 32'd2, 0);
    checkOutput("MULT HI const", HI, 32'hFFFF_FFFF);
    checkOutput("MULT LO const", LO, 32'hFFFF_FFFE);
    applyStimulus(4'd2, 32'hFFFF_FFFF, 32'd2, 0);
    checkOutput("MULTU HI const", HI, 32'd1);
    checkOutput("MULTU LO const", LO, 32'hFFFF_FFFE);

    applyStimulus(4'd7, 32'h1234_5678, 32'd0, 0);
    checkReads();
    checkOutput("MFHI const", MDUOut, 32'd0);
    mdu_op = 4'd5; #1;
    checkOutput("MTHI readback", MDUOut, 32'h1234_5678);
    mdu_op = 4'd0;
    applyStimulus(4'd8, 32'hCAFE_F00D, 32'd0, 0);

    applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(4'd4, 32'd7, 32'd0, 0);
    applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(4'd3, 32'd100, 32'hFFFF_FFF9, 0);

    // Stray MTLO and operand changes during a multiply must be ignored.
    applyStimulus(4'd1, 32'h0001_0003, 32'hFFFF_0005, 3);
    applyStimulus(4'd2, 32'h8000_0001, 32'h8000_0001, 1);

    // Reset on busy cycle 4 drops the pending result.
    start = 1'b1; mdu_op = DIV_EN ? 4'd3 : 4'd1; SA = 32'h0000_0999; SB = 32'd3;
    tick();
    start = 1'b0; mdu_op = 4'd0;
    tick(); tick(); tick();
    checkOutput("busy before mid reset", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    start = 1'b1; mdu_op = 4'd7; SA = 32'hDEAD_BEEF;
    tick();
    reset = 1'b1; start = 1'b0; mdu_op = 4'd0;
    expHi = 32'd0; expLo = 32'd0;
    checkOutput("busy after mid reset", {31'd0, busy}, 32'd0);
    checkOutput("HI after mid reset", HI, 32'd0);
    checkOutput("LO after mid reset", LO, 32'd0);
    applyStimulus(4'd1, 32'd12345, 32'hFFFF_FF00, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 4) == 0) rb = 32'hFFFF_FFFF;
      applyStimulus(rop, ra, rb, (rop == 4'd1 || rop == 4'd3) ? 2 : 0);
    end
    checkReads();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
